// File: rtl/jtframe_pocket_pkg.sv
// Shared definitions for the Pocket ROM download path: bridge address map,
// status register layout and serializer states.
package jtframe_pocket_pkg;

   // Default bridge address map
   localparam logic [31:0] DEF_DATA_BASE = 32'h1000_0000;
   localparam logic [31:0] DEF_CTRL_ADDR = 32'hF800_0000;

   // Register offsets from the control address
   localparam logic [31:0] REG_STATUS = 32'd0;
   localparam logic [31:0] REG_COUNT  = 32'd4;
   localparam logic [31:0] REG_CKSUM  = 32'd8;

   // Status word bit positions
   localparam int STAT_DWNLD   = 0;
   localparam int STAT_BUSY    = 1;
   localparam int STAT_LVL_LSB = 2;
   localparam int STAT_LVL_W   = 6;
   localparam int STAT_OVF     = 31;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EMIT,
      GAP
   } ser_state_e;

endpackage

// File: rtl/jtframe_pocket_fifo.sv
// Single-clock word FIFO absorbing bridge write bursts.
// Depth is 2**FIFO_AW; pointers carry one extra bit to tell full from empty.
module jtframe_pocket_fifo #(
   parameter int FIFO_AW = 3,
   parameter int DW      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [DW-1:0]    din,
   output logic [DW-1:0]    dout,
   output logic             full,
   output logic             empty,
   output logic [FIFO_AW:0] level
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [DW-1:0]    mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;

   assign level = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign dout  = mem[rd_ptr_q[FIFO_AW-1:0]];

   // Pointer update: flush wins, otherwise guarded push/pop
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push && !full)  wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop  && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write
   // NOTE: the array has no reset; its contents are only visible behind the pointers, which are reset.
   always_ff @(posedge clk) begin
      if (!flush && push && !full) mem[wr_ptr_q[FIFO_AW-1:0]] <= din;
   end

endmodule

// File: rtl/jtframe_pocket_dwnld.sv
// APF bridge to byte-wide ioctl download stream.
// Bridge words land in a small FIFO; a paced serializer emits them MSB byte
// first. Optional feature macro: JTFRAME_DWNLD_CKSUM_EN (16-bit byte sum
// readable at CTRL_ADDR+8).
module jtframe_pocket_dwnld
   import jtframe_pocket_pkg::*;
#(
   parameter int          AW        = 25,
   parameter int          FIFO_AW   = 3,
   parameter int          WR_GAP    = 4,
   parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
   parameter logic [31:0] CTRL_ADDR = DEF_CTRL_ADDR
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   bridge_addr,
   input  logic          bridge_wr,
   input  logic [31:0]   bridge_wr_data,
   input  logic          bridge_rd,
   output logic [31:0]   bridge_rd_data,
   output logic [AW-1:0] ioctl_addr,
   output logic [7:0]    ioctl_dout,
   output logic          ioctl_wr,
   output logic          downloading,
   output logic          dwnld_busy,
   output logic          overflow
);

   localparam int            GW       = $clog2(WR_GAP);
   localparam logic [GW-1:0] GAP_LAST = GW'(WR_GAP - 2);

   logic ctrl_wr, start, stop, push_req;
   logic fifo_full, fifo_empty, fifo_pop;
   logic [FIFO_AW:0] fifo_level;
   logic [31:0]      fifo_dout;

   ser_state_e    state_q, state_d;
   logic [31:0]   word_q, word_d;
   logic [1:0]    idx_q, idx_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [AW-1:0] cnt_q, cnt_d, addr_q, addr_d;
   logic [7:0]    dout_q, dout_d;
   logic          ovf_q, ovf_d, dl_q, dl_d, stop_pend_q, stop_pend_d;
   logic [31:0]   rd_data_q, rd_data_d, status;
   logic [15:0]   cksum_rd;

   assign ctrl_wr  = bridge_wr && (bridge_addr == CTRL_ADDR);
   assign start    = ctrl_wr &&  bridge_wr_data[0];
   assign stop     = ctrl_wr && !bridge_wr_data[0];
   assign push_req = bridge_wr && (bridge_addr[31:28] == DATA_BASE[31:28]) &&
                     dl_q && !stop_pend_q;

   jtframe_pocket_fifo #(.FIFO_AW(FIFO_AW), .DW(32)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (start),
      .push  (push_req),
      .pop   (fifo_pop),
      .din   (bridge_wr_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign ioctl_wr       = (state_q == EMIT);
   assign ioctl_addr     = addr_q;
   assign ioctl_dout     = dout_q;
   assign downloading    = dl_q;
   assign overflow       = ovf_q;
   assign dwnld_busy     = dl_q || !fifo_empty || (state_q != IDLE);
   assign bridge_rd_data = rd_data_q;

   // Serializer sequencing plus session control (start/stop/overflow)
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      ovf_d       = ovf_q;
      dl_d        = dl_q;
      stop_pend_d = stop_pend_q;
      fifo_pop    = 1'b0;
      unique case (state_q)
         IDLE: if (!fifo_empty) begin
            state_d  = LOAD;
            word_d   = fifo_dout;
            idx_d    = '0;
            fifo_pop = 1'b1;
         end
         LOAD: begin
            state_d = EMIT;
            dout_d  = word_q[31:24];
            addr_d  = cnt_q;
         end
         EMIT: begin
            state_d = GAP;
            gap_d   = '0;
            word_d  = {word_q[23:0], 8'h00};
         end
         GAP: if (gap_q == GAP_LAST) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) ovf_d = 1'b1;
            if (idx_q != 2'd3) begin
               idx_d   = idx_q + 1'b1;
               state_d = EMIT;
               dout_d  = word_q[31:24];
               addr_d  = cnt_q + 1'b1;
            end else if (!fifo_empty) begin
               state_d  = LOAD;
               word_d   = fifo_dout;
               idx_d    = '0;
               fifo_pop = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end else begin
            gap_d = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (push_req && fifo_full) ovf_d = 1'b1;
      if (stop) stop_pend_d = 1'b1;
      // A pending stop completes once nothing is queued or in flight
      if (stop_pend_q && fifo_empty && state_d == IDLE) begin
         dl_d        = 1'b0;
         stop_pend_d = 1'b0;
      end
      if (start) begin
         state_d     = IDLE;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         dl_d        = 1'b1;
         stop_pend_d = 1'b0;
         fifo_pop    = 1'b0;
      end
   end

   // Bridge read decode; unmapped addresses read zero
   always_comb begin
      status                                 = '0;
      status[STAT_OVF]                       = ovf_q;
      status[STAT_LVL_LSB +: STAT_LVL_W]     = STAT_LVL_W'(fifo_level);
      status[STAT_BUSY]                      = dwnld_busy;
      status[STAT_DWNLD]                     = dl_q;
      rd_data_d = '0;
      if (bridge_rd) begin
         if (bridge_addr == CTRL_ADDR + REG_STATUS)     rd_data_d = status;
         else if (bridge_addr == CTRL_ADDR + REG_COUNT) rd_data_d = 32'(cnt_q);
         else if (bridge_addr == CTRL_ADDR + REG_CKSUM) rd_data_d = {16'h0000, cksum_rd};
      end
   end

   // Serializer, session and read-data registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         idx_q       <= '0;
         gap_q       <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         dout_q      <= '0;
         ovf_q       <= 1'b0;
         dl_q        <= 1'b0;
         stop_pend_q <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         ovf_q       <= ovf_d;
         dl_q        <= dl_d;
         stop_pend_q <= stop_pend_d;
         rd_data_q   <= rd_data_d;
      end
   end

`ifdef JTFRAME_DWNLD_CKSUM_EN
   logic [15:0] cksum_q, cksum_d;

   // Running sum of emitted bytes, restarted with each session
   always_comb begin
      cksum_d = cksum_q;
      if (start)                 cksum_d = '0;
      else if (state_q == EMIT)  cksum_d = cksum_q + {8'h00, dout_q};
   end

   // Checksum register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cksum_q <= '0;
      else        cksum_q <= cksum_d;
   end

   assign cksum_rd = cksum_q;
`else
   assign cksum_rd = '0;
`endif

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Self-checking bench for jtframe_pocket_dwnld: a scoreboard of expected
// (addr, byte) pairs is filled as data words are written and drained by a
// monitor on every ioctl_wr pulse.
module tb_jtframe_pocket_dwnld;

   localparam int          AW      = 25;
   localparam int          FIFO_AW = 3;
   localparam int          WR_GAP  = 4;
   localparam logic [31:0] CTRL    = 32'hF800_0000;
   localparam logic [31:0] DATA    = 32'h1000_0000;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    dout;
   } exp_t;

   logic          clk, rst_n;
   logic [31:0]   bridge_addr, bridge_wr_data, bridge_rd_data;
   logic          bridge_wr, bridge_rd;
   logic [AW-1:0] ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic          ioctl_wr, downloading, dwnld_busy, overflow;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_wr     = 0;
   int   cyc      = 0;
   exp_t exp_q[$];
   int   wr_cyc_q[$];
   exp_t mon_e;

   jtframe_pocket_dwnld #(.AW(AW), .FIFO_AW(FIFO_AW), .WR_GAP(WR_GAP),
                          .DATA_BASE(DATA), .CTRL_ADDR(CTRL)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bridge_addr    (bridge_addr),
      .bridge_wr      (bridge_wr),
      .bridge_wr_data (bridge_wr_data),
      .bridge_rd      (bridge_rd),
      .bridge_rd_data (bridge_rd_data),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wr       (ioctl_wr),
      .downloading    (downloading),
      .dwnld_busy     (dwnld_busy),
      .overflow       (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard drain: every byte pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && ioctl_wr) begin
         n_wr++;
         wr_cyc_q.push_back(cyc);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ioctl_unexpected: got addr=%0d dout=%02h, required no write",
                     ioctl_addr, ioctl_dout);
         end else begin
            mon_e = exp_q.pop_front();
            if (ioctl_addr !== mon_e.addr || ioctl_dout !== mon_e.dout) begin
               n_fail++;
               $display("FAIL ioctl_byte: got addr=%0d dout=%02h, required addr=%0d dout=%02h",
                        ioctl_addr, ioctl_dout, mon_e.addr, mon_e.dout);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_word(input int base, input logic [31:0] w);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.addr = AW'(base + i);
         e.dout = w[31-8*i -: 8];
         exp_q.push_back(e);
      end
   endtask

   task automatic bwrite(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
      @(negedge clk);
      bridge_wr = 1'b0; bridge_addr = '0;
   endtask

   task automatic bread(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bridge_addr = a; bridge_rd = 1'b1;
      @(negedge clk);
      bridge_rd = 1'b0; bridge_addr = '0;
      d = bridge_rd_data;
   endtask

   // Back-to-back data writes; the first n_acc words are expected to be accepted
   task automatic burst(input int n, input int n_acc);
      logic [31:0] w;
      for (int i = 0; i < n; i++) begin
         w = $urandom();
         @(negedge clk);
         bridge_addr = DATA + 32'(4*i); bridge_wr_data = w; bridge_wr = 1'b1;
         if (i < n_acc) push_word(4*i, w);
      end
      @(negedge clk);
      bridge_wr = 1'b0; bridge_addr = '0;
   endtask

   task automatic wait_wr(input int target, input int budget, input string name);
      int k;
      for (k = 0; k < budget && n_wr < target; k++) tick();
      if (n_wr < target) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout: got %0d byte writes, required %0d", name, n_wr, target);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({ioctl_addr, ioctl_dout, ioctl_wr, downloading, dwnld_busy, overflow} !== '0 ||
          bridge_rd_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got addr=%0d dout=%02h wr=%b dl=%b busy=%b ovf=%b rd=%08h, required all 0",
                  ioctl_addr, ioctl_dout, ioctl_wr, downloading, dwnld_busy, overflow, bridge_rd_data);
      end
      @(negedge clk) rst_n = 1'b1;
      bread(CTRL, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %08h, required 00000000", d); end
      bread(CTRL + 4, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %08h, required 00000000", d); end
   endtask

   task automatic test_single_word();
      logic [31:0] d;
      logic [15:0] exp_ck;
      int t, n0;
      bwrite(CTRL, 32'h1);
      n_checks++;
      if (downloading !== 1'b1) begin n_fail++; $display("FAIL start_dl: got %b, required 1", downloading); end
      n0 = n_wr;
      wr_cyc_q.delete();
      push_word(0, 32'hA1B2C3D4);
      bwrite(DATA, 32'hA1B2C3D4);
      t = cyc;
      wait_wr(n0 + 4, 40, "single");
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (wr_cyc_q.size() <= i || wr_cyc_q[i] !== t + 2 + WR_GAP*i) begin
            n_fail++;
            $display("FAIL single_timing%0d: got cycle %0d, required %0d", i,
                     (wr_cyc_q.size() > i) ? wr_cyc_q[i] - t : -1, 2 + WR_GAP*i);
         end
      end
      repeat (WR_GAP + 2) tick();
      bread(CTRL + 4, d);
      n_checks++;
      if (d !== 32'd4) begin n_fail++; $display("FAIL single_count: got %0d, required 4", d); end
`ifdef JTFRAME_DWNLD_CKSUM_EN
      exp_ck = 16'h00A1 + 16'h00B2 + 16'h00C3 + 16'h00D4;
`else
      exp_ck = 16'h0000;
`endif
      bread(CTRL + 8, d);
      n_checks++;
      if (d !== {16'h0, exp_ck}) begin n_fail++; $display("FAIL cksum: got %08h, required %08h", d, {16'h0, exp_ck}); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      bwrite(CTRL, 32'h1);
      burst(8, 8);
      wait_wr(n_wr + 32 - (8*4 - exp_q.size()), 400, "b2b");
      repeat (WR_GAP + 2) tick();
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b, required 0", overflow); end
      bread(CTRL + 4, d);
      n_checks++;
      if (d !== 32'd32) begin n_fail++; $display("FAIL b2b_count: got %0d, required 32", d); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      bwrite(CTRL, 32'h1);
      burst(10, 9);
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
      bread(CTRL, d);
      n_checks++;
      if (d[31] !== 1'b1) begin n_fail++; $display("FAIL ovf_status: got bit31=%b, required 1", d[31]); end
      wait_wr(n_wr + exp_q.size(), 400, "ovf");
      repeat (WR_GAP + 2) tick();
      bread(CTRL + 4, d);
      n_checks++;
      if (d !== 32'd36) begin n_fail++; $display("FAIL ovf_count: got %0d, required 36", d); end
      bwrite(CTRL, 32'h1);
      bread(CTRL, d);
      n_checks++;
      if (d[31] !== 1'b0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear: got bit31=%b ovf=%b, required 0", d[31], overflow);
      end
   endtask

   task automatic test_stop();
      int n0, k;
      logic dl_ok;
      bwrite(CTRL, 32'h1);
      n0 = n_wr;
      burst(3, 3);
      bwrite(CTRL, 32'h0);
      bwrite(DATA, 32'hDEADBEEF);
      dl_ok = 1'b1;
      for (k = 0; k < 200 && n_wr < n0 + 12; k++) begin
         tick();
         if (downloading !== 1'b1) dl_ok = 1'b0;
      end
      n_checks++;
      if (n_wr < n0 + 12) begin n_fail++; $display("FAIL stop_timeout: got %0d bytes, required 12", n_wr - n0); end
      repeat (WR_GAP - 1) begin
         if (downloading !== 1'b1) dl_ok = 1'b0;
         tick();
      end
      n_checks++;
      if (!dl_ok || downloading !== 1'b1) begin
         n_fail++; $display("FAIL stop_early: got downloading=%b before last GAP ended, required 1", downloading);
      end
      tick();
      n_checks++;
      if (downloading !== 1'b0 || dwnld_busy !== 1'b0) begin
         n_fail++; $display("FAIL stop_end: got dl=%b busy=%b, required 0 0", downloading, dwnld_busy);
      end
   endtask

   task automatic test_idle_write();
      logic [31:0] d;
      int n0;
      n0 = n_wr;
      bwrite(DATA, 32'h55AA_1234);
      repeat (30) tick();
      n_checks++;
      if (n_wr !== n0) begin n_fail++; $display("FAIL idle_wr: got %0d writes, required 0", n_wr - n0); end
      bread(CTRL, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL idle_status: got %08h, required 00000000", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      exp_t e;
      int n0;
      bwrite(CTRL, 32'h1);
      n0 = n_wr;
      for (int i = 0; i < 3; i++) begin
         e.addr = AW'(i);
         e.dout = 8'h11 * 8'(i + 1);
         exp_q.push_back(e);
      end
      bwrite(DATA, 32'h1122_3344);
      wait_wr(n0 + 3, 40, "rstmid");
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ioctl_addr, ioctl_dout, ioctl_wr, downloading, dwnld_busy, overflow} !== '0 ||
          bridge_rd_data !== 32'h0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got addr=%0d dout=%02h wr=%b dl=%b busy=%b ovf=%b, required all 0",
                  ioctl_addr, ioctl_dout, ioctl_wr, downloading, dwnld_busy, overflow);
      end
      repeat (2) tick();
      @(negedge clk) rst_n = 1'b1;
      repeat (30) tick();
      bread(CTRL, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_status: got %08h, required 00000000", d); end
      bread(CTRL + 4, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_count: got %08h, required 00000000", d); end
   endtask

   initial begin
      rst_n = 1'b0;
      bridge_addr = '0; bridge_wr_data = '0; bridge_wr = 1'b0; bridge_rd = 1'b0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_stop();
      test_idle_write();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d pending bytes, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
